oc8051_fv_assert_mon: RTL and testbench

- Downstream consumer of oc8051_fv_top's assert_valid output in the formal-verification simulation flow.
- Counts run cycles after load and records the first violation cycle and the total violation count.
- Ends the run on a cycle budget or, optionally, on the first failure.
- Presents a single 32-bit result word over a valid/ack handshake so the bench, or a later on-chip reporter, can log pass/fail without parsing VCD.

---
 rtl/oc8051_fv_pkg.sv | 20 ++
 rtl/oc8051_fv_sat_cnt.sv | 17 +
 rtl/oc8051_fv_assert_mon.sv | 104 ++++++++++
 tb/tb_oc8051_fv_assert_mon.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/oc8051_fv_pkg.sv
// Shared definitions for the oc8051 formal-verification assertion monitor.
package oc8051_fv_pkg;

  // Run phases of the monitor; PARKED is left only through ld.
  typedef enum logic [1:0] {
    FV_WARM   = 2'd0,
    FV_RUN    = 2'd1,
    FV_REPORT = 2'd2,
    FV_PARKED = 2'd3
  } fv_state_e;

  // Field layout of the 32-bit result word.
  localparam int RPT_PASS_BIT = 31;
  localparam int RPT_SEEN_BIT = 30;
  localparam int RPT_FCNT_LSB = 16;
  localparam int RPT_FCYC_LSB = 0;

  localparam int FV_DEFAULT_MAX_CYCLES = 2000;

endpackage

// File: rtl/oc8051_fv_sat_cnt.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module oc8051_fv_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment; an all-ones count holds.
  always_ff @(posedge clk) begin
    if (clr)                     count <= '0;
    else if (inc && (count != '1)) count <= count + W'(1);
  end

endmodule

// File: rtl/oc8051_fv_assert_mon.sv
// Watches assert_valid from oc8051_fv_top over a bounded run and offers a
// single pass/fail result word over a valid/ack handshake.
module oc8051_fv_assert_mon
  import oc8051_fv_pkg::*;
#(
  parameter int CYC_W      = 16,
  parameter int FAIL_W     = 8,
  parameter int MAX_CYCLES = FV_DEFAULT_MAX_CYCLES,
  parameter int WARMUP     = 2
) (
  input  logic              clk,
  input  logic              ld,
  input  logic              assert_valid,
  input  logic              stop_on_fail,
  input  logic              rpt_ack,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [CYC_W-1:0]  first_fail_cyc,
  output logic              fail_seen,
  output logic              done,
  output logic              pass,
  output logic              rpt_valid,
  output logic [31:0]       rpt_data
);

  generate
    if (MAX_CYCLES <= WARMUP) begin : g_chk_budget
      $error("MAX_CYCLES must exceed WARMUP");
    end
    if (longint'(MAX_CYCLES) > ((longint'(1) << CYC_W) - 1)) begin : g_chk_width
      $error("MAX_CYCLES does not fit in CYC_W without wrapping");
    end
  endgenerate

  localparam fv_state_e LOAD_STATE = (WARMUP == 0) ? FV_RUN : FV_WARM;

  fv_state_e state, state_nxt;
  logic      viol;
  logic [31:0] fcnt_ext, fcyc_ext;

  // Next state; ld overrides everything, including a pending handshake.
  always_comb begin
    state_nxt = state;
    viol      = 1'b0;
    case (state)
      FV_WARM:   if (cycle_cnt == CYC_W'(WARMUP - 1)) state_nxt = FV_RUN;
      FV_RUN: begin
        viol = !assert_valid;
        if ((cycle_cnt == CYC_W'(MAX_CYCLES - 1)) || (viol && stop_on_fail))
          state_nxt = FV_REPORT;
      end
      FV_REPORT: if (rpt_valid && rpt_ack) state_nxt = FV_PARKED;
      default:   state_nxt = state;
    endcase
    if (ld) state_nxt = LOAD_STATE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (ld) state <= LOAD_STATE;
    else    state <= state_nxt;
  end

  // Cycle counter, first-violation capture and registered report valid.
  always_ff @(posedge clk) begin
    if (ld) begin
      cycle_cnt      <= '0;
      fail_seen      <= 1'b0;
      first_fail_cyc <= '0;
      rpt_valid      <= 1'b0;
    end else begin
      if (state == FV_WARM || state == FV_RUN) cycle_cnt <= cycle_cnt + CYC_W'(1);
      if (viol && !fail_seen) begin
        fail_seen      <= 1'b1;
        first_fail_cyc <= cycle_cnt;
      end
      rpt_valid <= (state_nxt == FV_REPORT);
    end
  end

  oc8051_fv_sat_cnt #(.W(FAIL_W)) u_fail_cnt (
    .clk   (clk),
    .clr   (ld),
    .inc   (viol && !ld),
    .count (fail_cnt)
  );

  assign done = (state == FV_REPORT) || (state == FV_PARKED);
  assign pass = done && !fail_seen;

  // Counter fields are zero-extended or truncated into their report slots.
  assign fcnt_ext = 32'(fail_cnt);
  assign fcyc_ext = 32'(first_fail_cyc);

  // Result word assembly; frozen counters keep it stable during REPORT.
  always_comb begin
    rpt_data                                  = '0;
    rpt_data[RPT_PASS_BIT]                    = pass;
    rpt_data[RPT_SEEN_BIT]                    = fail_seen;
    rpt_data[RPT_FCNT_LSB +: 8]               = fcnt_ext[7:0];
    rpt_data[RPT_FCYC_LSB +: 16]              = fcyc_ext[15:0];
  end

endmodule

// File: tb/tb_oc8051_fv_assert_mon.sv
// Directed bench for the assertion monitor: a short-budget instance driven
// from a vector table plus a long-budget instance for saturation.
module tb_oc8051_fv_assert_mon;

  logic clk = 1'b0;
  logic ld = 1'b1, assert_valid = 1'b1, stop_on_fail = 1'b0, rpt_ack = 1'b1;

  logic [15:0] a_cyc, a_ffc, b_cyc, b_ffc;
  logic [7:0]  a_fcnt, b_fcnt;
  logic        a_seen, a_done, a_pass, a_rv, b_seen, b_done, b_pass, b_rv;
  logic [31:0] a_data, b_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  oc8051_fv_assert_mon #(.CYC_W(16), .FAIL_W(8), .MAX_CYCLES(16), .WARMUP(2)) dut_a (
    .clk(clk), .ld(ld), .assert_valid(assert_valid), .stop_on_fail(stop_on_fail),
    .rpt_ack(rpt_ack), .cycle_cnt(a_cyc), .fail_cnt(a_fcnt), .first_fail_cyc(a_ffc),
    .fail_seen(a_seen), .done(a_done), .pass(a_pass), .rpt_valid(a_rv), .rpt_data(a_data)
  );

  oc8051_fv_assert_mon #(.CYC_W(16), .FAIL_W(8), .MAX_CYCLES(400), .WARMUP(2)) dut_b (
    .clk(clk), .ld(ld), .assert_valid(assert_valid), .stop_on_fail(stop_on_fail),
    .rpt_ack(rpt_ack), .cycle_cnt(b_cyc), .fail_cnt(b_fcnt), .first_fail_cyc(b_ffc),
    .fail_seen(b_seen), .done(b_done), .pass(b_pass), .rpt_valid(b_rv), .rpt_data(b_data)
  );

  typedef struct {
    string       name;
    logic [31:0] bad_mask;   // bit k set: assert_valid=0 when cycle_cnt==k
    logic        stop;
    logic [15:0] exp_cyc;
    logic [7:0]  exp_fcnt;
    logic [15:0] exp_ffc;
    logic        exp_seen;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Two load cycles, then the bench sits just after a negedge with ld still 1.
  task automatic do_load();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Releases ld and drives assert_valid from the mask until dut_a reports.
  task automatic run_a(input logic [31:0] mask, input string name);
    int k = 0;
    ld = 1'b0;
    while (!a_done && k < 60) begin
      assert_valid = (k < 32) ? !mask[k] : 1'b1;
      @(negedge clk);
      k++;
    end
    assert_valid = 1'b1;
    chk({name, " done_reached"}, {31'd0, a_done}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{"all_valid",   32'h0000_0000, 1'b0, 16'd16, 8'd0,  16'd0,  1'b0, 32'h8000_0000};
    vecs[1] = '{"viol_5_9",    32'h0000_0220, 1'b0, 16'd16, 8'd2,  16'd5,  1'b1, 32'h4002_0005};
    vecs[2] = '{"stop_5",      32'h0000_0220, 1'b1, 16'd6,  8'd1,  16'd5,  1'b1, 32'h4001_0005};
    vecs[3] = '{"warm_ignore", 32'h0000_0003, 1'b0, 16'd16, 8'd0,  16'd0,  1'b0, 32'h8000_0000};
    vecs[4] = '{"all_bad",     32'hFFFF_FFFF, 1'b0, 16'd16, 8'd14, 16'd2,  1'b1, 32'h400E_0002};
    vecs[5] = '{"edges_2_15",  32'h0000_8004, 1'b0, 16'd16, 8'd2,  16'd2,  1'b1, 32'h4002_0002};
    vecs[6] = '{"stop_last",   32'h0000_8000, 1'b1, 16'd16, 8'd1,  16'd15, 1'b1, 32'h4001_000F};

    for (int i = 0; i < 7; i++) begin
      stop_on_fail = vecs[i].stop;
      rpt_ack      = 1'b1;
      assert_valid = 1'b1;
      do_load();
      chk({vecs[i].name, " rst_cyc"},  {16'd0, a_cyc}, 32'd0);
      chk({vecs[i].name, " rst_data"}, a_data, 32'd0);
      chk({vecs[i].name, " rst_done"}, {30'd0, a_done, a_rv}, 32'd0);
      run_a(vecs[i].bad_mask, vecs[i].name);
      chk({vecs[i].name, " cyc"},   {16'd0, a_cyc},  {16'd0, vecs[i].exp_cyc});
      chk({vecs[i].name, " fcnt"},  {24'd0, a_fcnt}, {24'd0, vecs[i].exp_fcnt});
      chk({vecs[i].name, " ffc"},   {16'd0, a_ffc},  {16'd0, vecs[i].exp_ffc});
      chk({vecs[i].name, " seen"},  {31'd0, a_seen}, {31'd0, vecs[i].exp_seen});
      chk({vecs[i].name, " pass"},  {31'd0, a_pass}, {31'd0, !vecs[i].exp_seen});
      chk({vecs[i].name, " rv"},    {31'd0, a_rv},   32'd1);
      chk({vecs[i].name, " data"},  a_data, vecs[i].exp_data);
      @(negedge clk);
      chk({vecs[i].name, " parked_rv"},   {31'd0, a_rv},   32'd0);
      chk({vecs[i].name, " parked_done"}, {31'd0, a_done}, 32'd1);
      chk({vecs[i].name, " parked_cyc"},  {16'd0, a_cyc},  {16'd0, vecs[i].exp_cyc});
    end

    // Saturation on the long-budget instance.
    stop_on_fail = 1'b0;
    rpt_ack      = 1'b1;
    assert_valid = 1'b0;
    do_load();
    ld = 1'b0;
    for (int k = 0; k < 300; k++) @(negedge clk);
    assert_valid = 1'b1;
    begin
      int n = 0;
      while (!b_done && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("sat done",  {31'd0, b_done}, 32'd1);
    chk("sat fcnt",  {24'd0, b_fcnt}, 32'h0000_00FF);
    chk("sat ffc",   {16'd0, b_ffc},  32'd2);
    chk("sat cyc",   {16'd0, b_cyc},  32'd400);
    chk("sat data",  b_data, 32'h40FF_0002);

    // Held-off ack, then ld in the middle of the handshake.
    stop_on_fail = 1'b0;
    rpt_ack      = 1'b0;
    assert_valid = 1'b1;
    do_load();
    run_a(32'h0, "hold");
    for (int k = 0; k < 10; k++) begin
      chk("hold rv",   {31'd0, a_rv}, 32'd1);
      chk("hold data", a_data, 32'h8000_0000);
      @(negedge clk);
    end
    ld = 1'b1;
    @(negedge clk);
    chk("ld cyc",  {16'd0, a_cyc}, 32'd0);
    chk("ld fcnt", {24'd0, a_fcnt}, 32'd0);
    chk("ld ffc",  {16'd0, a_ffc}, 32'd0);
    chk("ld flags", {28'd0, a_seen, a_done, a_pass, a_rv}, 32'd0);
    chk("ld data", a_data, 32'd0);
    ld = 1'b0;
    @(negedge clk);
    chk("restart cyc", {16'd0, a_cyc}, 32'd1);
    chk("restart done", {31'd0, a_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
